// File: rtl/pipe_types_pkg.sv
// Shared definitions for the inter-stage pipeline buffers.
package pipe_types_pkg;

  localparam int PIPE_DEPTH_REG      = 1;
  localparam int PIPE_DEPTH_SKID     = 2;
  localparam int PIPE_CNT_W_DEFAULT  = 16;

  // Occupancy of a stage buffer, encoded as {head_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } pipe_occ_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module pipe_sat_cnt
  import pipe_types_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, otherwise step unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready stage buffer: plain register (DEPTH=1) or skid buffer
// (DEPTH=2) with flush and stall/bubble performance counters.
module pipe_stage_buf
  import pipe_types_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = PIPE_DEPTH_REG,
  parameter int CNT_W      = PIPE_CNT_W_DEFAULT,
  parameter int FLUSH_ZERO = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  input  logic             cnt_clr
);

  if ((DEPTH != PIPE_DEPTH_REG) && (DEPTH != PIPE_DEPTH_SKID)) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be 1 or 2");
  end
  if ((WIDTH < 1) || (WIDTH > 512)) begin : g_bad_width
    $error("pipe_stage_buf: WIDTH must be in 1..512");
  end

  pipe_occ_t        occ_q;
  pipe_occ_t        occ_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             accept;
  logic             consume;
  logic             stall_inc;
  logic             bubble_inc;

  assign accept     = in_valid & in_ready;
  assign consume    = out_valid & out_ready;
  assign stall_inc  = out_valid & ~out_ready;
  assign bubble_inc = ~out_valid;

  // Occupancy and payload registers; reset throws away every entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occ_q  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Next occupancy and payload moves; flush overrides every handshake.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = EMPTY;
      if (FLUSH_ZERO != 0) begin
        head_d = '0;
        skid_d = '0;
      end
    end else begin
      case (occ_q)
        EMPTY: begin
          if (accept) begin
            occ_d  = ONE;
            head_d = in_data;
          end
        end
        ONE: begin
          if (accept && consume) begin
            head_d = in_data;
          end else if (consume) begin
            occ_d = EMPTY;
          end else if (accept && (DEPTH == PIPE_DEPTH_SKID)) begin
            occ_d  = FULL;
            skid_d = in_data;
          end
        end
        FULL: begin
          if (consume) begin
            occ_d  = ONE;
            head_d = skid_q;
          end
        end
        default: begin
          occ_d = EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs; the skid variant derives in_ready from a flop only.
  always_comb begin
    out_valid = (occ_q != EMPTY);
    out_data  = head_q;
    if (DEPTH == PIPE_DEPTH_SKID) begin
      in_ready = (occ_q != FULL);
    end else begin
      in_ready = (occ_q == EMPTY) | out_ready;
    end
  end

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (stall_inc),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (bubble_inc),
    .clr (cnt_clr),
    .cnt (bubble_cnt)
  );

endmodule
